// File: rtl/alu_rmw_sequencer.sv
// Read-modify-write sequencer for 6502 memory-operand INC/DEC/ASL/LSR/ROL/ROR.
// Define RMW_DUMMY_WRITE_EN for the NMOS dummy write of the unmodified operand.
module alu_rmw_sequencer #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_cin,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_op,
   output logic              alu_cin,
   input  logic [7:0]        alu_result,
   input  logic              alu_c,
   input  logic              alu_z,
   input  logic              alu_n,
   output logic              done,
   output logic              err,
   output logic              flag_c,
   output logic              flag_z,
   output logic              flag_n,
   output logic              we_c,
   output logic              we_nz
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_MODIFY, S_DUMMY, S_WRITE, S_DONE
   } state_t;

   localparam logic [3:0] OP_INC   = 4'b0101;
   localparam logic [3:0] OP_DEC   = 4'b0110;
   localparam logic [3:0] OP_PASSA = 4'b0111;
   localparam logic [3:0] OP_ASL   = 4'b1001;
   localparam logic [3:0] OP_LSR   = 4'b1010;
   localparam logic [3:0] OP_ROL   = 4'b1011;
   localparam logic [3:0] OP_ROR   = 4'b1100;

   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_INC, OP_DEC, OP_ASL, OP_LSR, OP_ROL, OP_ROR};
   endfunction

   // INC and DEC leave the carry flag alone; only the shifts/rotates write it.
   function automatic logic op_sets_c(input logic [3:0] op);
      return op inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR};
   endfunction

   state_t            state, state_nxt;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cin_q;
   logic              err_q;
   logic [7:0]        operand_q;
   logic [7:0]        result_q;

   assign mem_addr = addr_q;
   assign alu_a    = operand_q;
   assign alu_b    = 8'h00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= 4'h0;
         addr_q    <= '0;
         cin_q     <= 1'b0;
         err_q     <= 1'b0;
         operand_q <= 8'h00;
         result_q  <= 8'h00;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            cin_q  <= req_cin;
            err_q  <= !op_legal(req_op);
         end
         if (state == S_READ && mem_ack) begin
            operand_q <= mem_rdata;
         end
         // Flags stay put from here until the next transaction's modify cycle.
         if (state == S_MODIFY) begin
            result_q <= alu_result;
            flag_c   <= alu_c;
            flag_z   <= alu_z;
            flag_n   <= alu_n;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = 8'h00;
      alu_op    = OP_PASSA;
      alu_cin   = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      we_c      = 1'b0;
      we_nz     = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = op_legal(req_op) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            mem_rd = 1'b1;
            if (mem_ack) state_nxt = S_MODIFY;
         end
         S_MODIFY: begin
            alu_op  = op_q;
            alu_cin = cin_q;
`ifdef RMW_DUMMY_WRITE_EN
            state_nxt = S_DUMMY;
`else
            state_nxt = S_WRITE;
`endif
         end
         S_DUMMY: begin
            mem_wr    = 1'b1;
            mem_wdata = operand_q;
            if (mem_ack) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            mem_wr    = 1'b1;
            mem_wdata = result_q;
            if (mem_ack) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            err       = err_q;
            we_nz     = !err_q;
            we_c      = !err_q && op_sets_c(op_q);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Directed and randomized bench for alu_rmw_sequencer with a bus responder and ALU model.
module tb_alu_rmw_sequencer;

`ifdef RMW_DUMMY_WRITE_EN
   localparam bit DUMMY = 1'b1;
`else
   localparam bit DUMMY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_addr;
   logic        req_cin;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_op;
   logic        alu_cin;
   logic [7:0]  alu_result;
   logic        alu_c;
   logic        alu_z;
   logic        alu_n;
   logic        done;
   logic        err;
   logic        flag_c;
   logic        flag_z;
   logic        flag_n;
   logic        we_c;
   logic        we_nz;

   int n_cmp = 0;
   int n_bad = 0;

   alu_rmw_sequencer #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_cin(req_cin),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
      .done(done), .err(err), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
      .we_c(we_c), .we_nz(we_nz)
   );

   always #5 clk = ~clk;

   // Shared ALU stand-in
   always_comb begin
      alu_result = alu_a;
      alu_c      = 1'b0;
      case (alu_op)
         4'b0101: alu_result = alu_a + 8'd1;
         4'b0110: alu_result = alu_a - 8'd1;
         4'b1001: {alu_c, alu_result} = {alu_a, 1'b0};
         4'b1010: {alu_result, alu_c} = {1'b0, alu_a};
         4'b1011: {alu_c, alu_result} = {alu_a, alu_cin};
         4'b1100: {alu_result, alu_c} = {alu_cin, alu_a};
         default: ;
      endcase
   end
   assign alu_z = (alu_result == 8'h00);
   assign alu_n = alu_result[7];

   // Bus responder: ack after wait_n cycles of strobe, or ack tied high
   bit         ack_always = 1'b0;
   int         wait_n = 0;
   int         wcnt = 0;
   logic [7:0] rd_val = 8'h00;
   assign mem_rdata = rd_val;
   assign mem_ack   = ack_always ? 1'b1 : ((mem_rd || mem_wr) && (wcnt == wait_n));

   always @(posedge clk) begin
      if ((mem_rd || mem_wr) && !mem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } xfer_t;
   xfer_t trace[$];

   always @(posedge clk) begin
      if (mem_ack && (mem_rd || mem_wr))
         trace.push_back('{wr: mem_wr, addr: mem_addr, data: (mem_rd ? mem_rdata : mem_wdata)});
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] op);
      return op == 4'h5 || op == 4'h6 || op == 4'h9 || op == 4'hA || op == 4'hB || op == 4'hC;
   endfunction

   function automatic bit is_shift(input logic [3:0] op);
      return op == 4'h9 || op == 4'hA || op == 4'hB || op == 4'hC;
   endfunction

   // 6502 semantics in plain integer arithmetic
   function automatic void ref_model(input logic [3:0] op, input int d, input bit cin,
                                     output int r, output bit c);
      r = d;
      c = 1'b0;
      case (op)
         4'h5: r = (d + 1) % 256;
         4'h6: r = (d + 255) % 256;
         4'h9: begin r = (d * 2) % 256;       c = (d >= 128); end
         4'hA: begin r = d / 2;               c = (d % 2 == 1); end
         4'hB: begin r = (d * 2 + cin) % 256; c = (d >= 128); end
         4'hC: begin r = d / 2 + 128 * cin;   c = (d % 2 == 1); end
         default: ;
      endcase
   endfunction

   // Starts and ends at a falling edge; returns in the idle cycle after done.
   task automatic run_op(input logic [3:0] op, input logic [15:0] addr, input logic [7:0] data,
                         input bit cin, input int waits, input bit tied);
      int n, exp_lat, r, nwr;
      bit got, strobe_seen, excl_bad, addr_bad, legal, c;
      logic hc, hz, hn;
      legal = is_legal(op);
      ack_always = tied;
      wait_n = waits;
      rd_val = data;
      trace.delete();
      chk1("ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      req_cin = cin;
      n = 0;
      got = 0;
      strobe_seen = 0;
      excl_bad = 0;
      addr_bad = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (mem_rd && mem_wr) excl_bad = 1;
         if (mem_rd || mem_wr) begin
            strobe_seen = 1;
            if (mem_addr !== addr) addr_bad = 1;
         end
         if (done) begin
            got = 1;
            break;
         end
         req_valid = 1'($urandom);
         req_op = 4'($urandom);
         req_addr = 16'($urandom);
         req_cin = 1'($urandom);
      end
      req_valid = 1'b0;
      nwr = DUMMY ? 2 : 1;
      exp_lat = legal ? ((DUMMY ? 5 : 4) + (tied ? 0 : waits * (1 + nwr))) : 1;
      chk1("done_seen", got, 1'b1);
      chk16("done_latency", 16'(n), 16'(exp_lat));
      chk1("err", err, !legal);
      chk1("we_nz", we_nz, legal);
      chk1("we_c", we_c, legal && is_shift(op));
      chk1("rd_wr_exclusive_violation", excl_bad, 1'b0);
      chk1("addr_changed", addr_bad, 1'b0);
      if (legal) begin
         ref_model(op, int'(data), cin, r, c);
         chk1("flag_z", flag_z, r == 0);
         chk1("flag_n", flag_n, r >= 128);
         if (is_shift(op)) chk1("flag_c", flag_c, c);
         chk16("xfer_count", 16'(trace.size()), 16'(1 + nwr));
         if (trace.size() == 1 + nwr) begin
            chk1("xfer0_is_read", trace[0].wr, 1'b0);
            chk16("xfer0_addr", trace[0].addr, addr);
            chk8("xfer0_data", trace[0].data, data);
            if (DUMMY) begin
               chk1("dummy_is_write", trace[1].wr, 1'b1);
               chk8("dummy_data", trace[1].data, data);
            end
            chk1("final_is_write", trace[nwr].wr, 1'b1);
            chk16("final_addr", trace[nwr].addr, addr);
            chk8("final_data", trace[nwr].data, 8'(r));
         end
      end else begin
         chk1("illegal_strobe", strobe_seen, 1'b0);
         chk16("illegal_xfer_count", 16'(trace.size()), 16'd0);
      end
      hc = flag_c;
      hz = flag_z;
      hn = flag_n;
      @(negedge clk);
      chk1("done_one_cycle", done, 1'b0);
      chk1("ready_after_done", req_ready, 1'b1);
      chk1("flag_c_hold", flag_c, hc);
      chk1("flag_z_hold", flag_z, hz);
      chk1("flag_n_hold", flag_n, hn);
   endtask

   initial begin
      int k;
      bit seen_done;
      logic [3:0] op;
      logic [3:0] legal_ops [6];
      legal_ops = '{4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC};
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 4'h0;
      req_addr = 16'h0000;
      req_cin = 1'b0;
      repeat (2) @(negedge clk);

      chk1("rst_ready", req_ready, 1'b1);
      chk1("rst_rd", mem_rd, 1'b0);
      chk1("rst_wr", mem_wr, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_we_c", we_c, 1'b0);
      chk1("rst_we_nz", we_nz, 1'b0);
      chk1("rst_flag_c", flag_c, 1'b0);
      chk1("rst_flag_z", flag_z, 1'b0);
      chk1("rst_flag_n", flag_n, 1'b0);
      chk16("rst_mem_addr", mem_addr, 16'h0000);
      chk8("rst_wdata", mem_wdata, 8'h00);
      chk8("rst_alu_a", alu_a, 8'h00);
      chk8("rst_alu_b", alu_b, 8'h00);
      chk16("rst_alu_op", 16'(alu_op), 16'h0007);
      rst = 1'b0;
      @(negedge clk);

      run_op(4'h5, 16'h0010, 8'hFF, 1'b0, 0, 1'b1);   // INC 0xFF, ack tied high
      run_op(4'hB, 16'h1234, 8'h80, 1'b1, 0, 1'b1);   // ROL 0x80 with C=1
      run_op(4'hA, 16'h0200, 8'h01, 1'b0, 2, 1'b0);   // LSR with two wait states
      run_op(4'h2, 16'h0300, 8'h55, 1'b0, 0, 1'b1);   // AND: illegal

      // Reset while the final write waits for ack
      ack_always = 1'b0;
      wait_n = 5;
      rd_val = 8'h10;
      trace.delete();
      req_valid = 1'b1;
      req_op = 4'h5;
      req_addr = 16'h0040;
      req_cin = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (k < 60 && !(mem_wr && mem_wdata == 8'h11)) begin
         @(negedge clk);
         k++;
      end
      chk1("midwrite_reached", mem_wr, 1'b1);
      chk1("midwrite_ack_low", mem_ack, 1'b0);
      rst = 1'b1;
      #1;
      chk1("rst_mid_wr_drop", mem_wr, 1'b0);
      chk1("rst_mid_ready", req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      chk1("rst_mid_no_done", seen_done, 1'b0);
      chk16("rst_mid_xfers", 16'(trace.size()), DUMMY ? 16'd2 : 16'd1);
      run_op(4'h6, 16'h0041, 8'h00, 1'b0, 0, 1'b1);   // DEC 0x00 -> 0xFF

      // Back-to-back
      run_op(4'h9, 16'h0500, 8'h40, 1'b0, 0, 1'b1);
      run_op(4'h6, 16'h0501, 8'h01, 1'b0, 0, 1'b1);

      for (int i = 0; i < 25; i++) begin
         int w;
         if ($urandom_range(0, 9) == 0) begin
            op = 4'($urandom);
            while (is_legal(op)) op = 4'($urandom);
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         w = $urandom_range(0, 2);
         run_op(op, 16'($urandom), 8'($urandom), 1'($urandom), w, (w == 0) && 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_rmw_sequencer.md
# alu_rmw_sequencer

Multi-cycle controller that runs 6502 read-modify-write memory instructions (INC, DEC, ASL, LSR, ROL, ROR on a memory operand) through the shared ALU. The CPU control unit issues one request. The block then sequences the bus read, the ALU modify cycle, the optional NMOS dummy write and the final write-back. It returns flag updates to the status register. It sits between the control unit, the ALU and the memory bus arbiter.

## Interface
Parameters:
- ADDR_W, 16, memory address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request strobe from control unit
- req_ready  out  1  block idle and able to accept
- req_op  in  4  ALU op code; legal: INC 0101, DEC 0110, ASL 1001, LSR 1010, ROL 1011, ROR 1100
- req_addr  in  ADDR_W  operand address
- req_cin  in  1  current C flag, used by ROL/ROR
- mem_addr  out  ADDR_W  bus address
- mem_rd  out  1  read strobe, held until ack
- mem_wr  out  1  write strobe, held until ack
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid in the ack cycle
- mem_ack  in  1  transfer completes at the rising edge where strobe and ack are both high
- alu_a  out  8  ALU A operand
- alu_b  out  8  ALU B operand, constant 0
- alu_op  out  4  ALU op select
- alu_cin  out  1  ALU carry in
- alu_result  in  8  ALU result
- alu_c, alu_z, alu_n  in  1 each  ALU flag outputs
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; illegal req_op
- flag_c, flag_z, flag_n  out  1 each  registered flag results
- we_c  out  1  write-enable for C, pulses with done
- we_nz  out  1  write-enable for N and Z, pulses with done

## Operation
- States: IDLE, READ, MODIFY, DUMMY, WRITE, DONE.
- **IDLE**
  - req_ready=1.
  - When req_valid=1, latch op, addr and cin.
  - Legal op: go to READ. Illegal op: go to DONE with err latched to 1.
- **READ**
  - mem_rd=1, mem_addr=addr.
  - On ack, capture mem_rdata into the operand register and go to MODIFY.
- **MODIFY** (exactly 1 cycle)
  - alu_a=operand, alu_op=latched op, alu_cin=latched cin.
  - Register alu_result, alu_c, alu_z and alu_n at the edge.
  - Next state is DUMMY if the macro is defined, else WRITE.
- **DUMMY**
  - mem_wr=1, mem_wdata=original operand, mem_addr=addr.
  - On ack, go to WRITE.
- **WRITE**
  - mem_wr=1, mem_wdata=registered result.
  - On ack, go to DONE.
- **DONE** (1 cycle)
  - done=1.
  - Legal op: we_nz=1. we_c=1 only for ASL, LSR, ROL and ROR; INC and DEC leave C untouched.
  - Illegal op: err=1, we_c=0, we_nz=0, and no bus access has occurred.
  - Next state is IDLE.
- **Idle-state outputs** outside the states above:
  - alu_op=0111 (PASSA), alu_a=operand register, alu_b=0.
  - mem_rd=mem_wr=0, mem_wdata=0.
- **Mutual exclusion**: mem_rd and mem_wr are never high together.
- **Held inputs**: mem_addr holds the latched addr for the whole transaction. Request inputs are ignored while req_ready=0.

## Timing
- **Reset values**, applied immediately on rst regardless of clock:
  - State=IDLE, req_ready=1.
  - All strobes, done, err and we_* = 0.
  - flag_c, flag_z, flag_n = 0; operand, result and mem_addr = 0.
- **Reset mid-transaction**: strobes drop immediately, the pending write is abandoned, and no done pulse is generated.
- **Latency with mem_ack tied high**: done is high in cycle 5 after the accept edge with the macro, or cycle 4 without it. Each wait state adds exactly one cycle.
- **Illegal op**: done and err are high in the first cycle after accept.
- **Back-to-back**: a new request can be accepted in the cycle after DONE, so there is a minimum 1-cycle IDLE gap.
- **Early ack**: a mem_ack arriving while no strobe is high is ignored.
- **Flag outputs**: flag_* stay valid from DONE until the next MODIFY.

## Configuration
- Macro: RMW_DUMMY_WRITE_EN.
- **Defined**: NMOS behaviour. The DUMMY state writes the unmodified operand before the final write, giving two bus writes per legal op.
- **Undefined**: the DUMMY state is unreachable. MODIFY goes straight to WRITE, giving one bus write per legal op and one cycle less latency.

## Test plan
- INC at 0x0010, memory 0xFF, ack tied high, macro on:
  - Bus sees rd 0x0010, then wr 0xFF, then wr 0x00.
  - done in cycle 5, flag_z=1, flag_n=0, we_nz=1, we_c=0.
- ROL at 0x1234, data 0x80, req_cin=1, macro off:
  - Single write of 0x01; done in cycle 4.
  - flag_c=1, flag_z=0, flag_n=0, we_c=1.
- LSR with 2 wait states on each transfer, data 0x01:
  - Strobes are held through the waits; write 0x00.
  - flag_c=1, flag_z=1; done 6 cycles later than with zero wait.
- req_op=0010 (AND, illegal):
  - No mem_rd or mem_wr ever asserted; done=err=1 in cycle 1; we_c=we_nz=0.
- rst asserted during WRITE with mem_ack low:
  - mem_wr=0 in the same cycle, no done pulse, req_ready=1.
  - A following DEC of 0x00 writes 0xFF with flag_n=1.
- Back-to-back:
  - ASL of 0x40 followed immediately by DEC of 0x01: second request accepted in the cycle after the first done.
  - Results are 0x80 and 0x00.
